// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS main controller.
// A Moore state machine steps each instruction through fetch, decode,
// execute, memory and write-back, one state per clock. The datapath
// enables and mux selects are decoded from the state register. PCEn,
// IRWrite and the branch/memory waits are additionally gated by MemReady
// and Zero.
module mc_control_fsm (
   input  logic       CLK,
   input  logic       RST,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [1:0] PCSrc,
   output logic       PCEn,
   output logic       Illegal,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t     state_q, state_d;
   state_t     out_state;
   logic       op_ok;
   logic       funct_ok;
   logic [2:0] funct_alu;

   assign op_ok = (Op == OP_RTYPE) || (Op == OP_LW) || (Op == OP_SW) ||
                  (Op == OP_BEQ)   || (Op == OP_ADDI) || (Op == OP_J);

   // While reset is held the outputs show the FETCH decode, whatever state is in flight.
   assign out_state = RST ? S_FETCH : state_q;
   assign State     = state_q;

   // Translate the R-type funct field into an ALU operation and flag unsupported codes.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
      funct_ok  = 1'b1;
      funct_alu = ALU_ADD;
      case (Funct)
         6'b100000: funct_alu = ALU_ADD;
         6'b100010: funct_alu = ALU_SUB;
         6'b100100: funct_alu = ALU_AND;
         6'b100101: funct_alu = ALU_OR;
         6'b101010: funct_alu = ALU_SLT;
         default:   funct_ok  = 1'b0;
      endcase
   end

   // Pick the next state from the current state, the opcode and the memory handshake.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:   state_d = MemReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (Op)
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:  state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   state_d = MemReady ? S_MEMWB : S_MEMRD;
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWR:   state_d = MemReady ? S_FETCH : S_MEMWR;
         S_EXECUTE: state_d = funct_ok ? S_ALUWB : S_FETCH;
         S_ALUWB:   state_d = S_FETCH;
         S_BRANCH:  state_d = S_FETCH;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_ADDIWB:  state_d = S_FETCH;
         S_JUMP:    state_d = S_FETCH;
         default:   state_d = S_FETCH;
      endcase
   end

   // State register; reset overrides any pending transition, including a memory wait.
   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values.
      if (RST) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   // Decode the datapath controls from the state; reset suppresses every enable.
   always_comb begin
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUControl = ALU_ADD;
      PCSrc      = 2'b00;
      PCEn       = 1'b0;
      Illegal    = 1'b0;
      case (out_state)
         S_FETCH: begin
            ALUSrcB = 2'b01;
            IRWrite = MemReady;
            PCEn    = MemReady;
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            Illegal = !op_ok;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD:  IorD = 1'b1;
         S_MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
         end
         S_MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXECUTE: begin
            ALUSrcA    = 1'b1;
            ALUControl = funct_alu;
            Illegal    = !funct_ok;
         end
         S_ALUWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUControl = ALU_SUB;
            PCSrc      = 2'b01;
            PCEn       = Zero;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_ADDIWB: RegWrite = 1'b1;
         S_JUMP: begin
            PCSrc = 2'b10;
            PCEn  = 1'b1;
         end
         default: ;
      endcase
      if (RST) begin
         MemWrite = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         PCEn     = 1'b0;
         Illegal  = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: bench for the multicycle MIPS main controller.
// Hand-written cycle sequences cover reset and the multi-cycle corners.
// A table of whole-instruction vectors and a randomized instruction stream
// are compared against an instruction-level model of latency and enable counts.
module tb_mc_control_fsm;

   logic       CLK = 1'b0;
   logic       RST;
   logic [5:0] Op, Funct;
   logic       Zero, MemReady;
   logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUControl;
   logic [1:0] PCSrc;
   logic       PCEn, Illegal;
   logic [3:0] State;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [5:0] op;
      logic [5:0] funct;
      logic       zero;
      int         fs;    // fetch cycles with MemReady low
      int         ms;    // memory-wait cycles with MemReady low
      int         lat;
      int         regw;
      int         memw;
      int         pcen;
      int         ill;
   } vec_t;

   typedef struct {
      int         lat;
      int         regw;
      int         memw;
      int         pcen;
      int         ill;
      logic       rd;
      logic       mtr;
      logic [2:0] alu;
   } exp_t;

   vec_t vecs [12];

   always #5 CLK = ~CLK;

   mc_control_fsm dut (
      .CLK(CLK), .RST(RST), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
      .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn), .Illegal(Illegal), .State(State)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Advance one clock: drive this cycle's inputs just after the edge, sample at the falling edge.
   task automatic cyc(input logic rst, input logic rdy, input logic zr);
      @(posedge CLK);
      #1;
      RST      = rst;
      MemReady = rdy;
      Zero     = zr;
      @(negedge CLK);
   endtask

   // Instruction-level model: latency and enable counts from the instruction class and wait cycles.
   function automatic exp_t model(input logic [5:0] op, input logic [5:0] funct,
                                  input logic [39:0] rdy, input logic [39:0] zr);
      exp_t e;
      int   fs, ms;
      logic r_ok;
      logic [2:0] alu;
      fs = 0;
      while (fs < 30 && !rdy[fs]) fs++;
      ms = 0;
      while (ms < 5 && !rdy[fs + 3 + ms]) ms++;
      r_ok = 1'b1;
      alu  = 3'b010;
      case (funct)
         6'b100000: alu = 3'b010;
         6'b100010: alu = 3'b110;
         6'b100100: alu = 3'b000;
         6'b100101: alu = 3'b001;
         6'b101010: alu = 3'b111;
         default:   r_ok = 1'b0;
      endcase
      e = '{lat: 0, regw: 0, memw: 0, pcen: 1, ill: 0, rd: 1'b0, mtr: 1'b0, alu: 3'b010};
      case (op)
         6'b100011: begin e.lat = 5 + fs + ms; e.regw = 1; e.mtr = 1'b1; end
         6'b101011: begin e.lat = 4 + fs + ms; e.memw = ms + 1; end
         6'b000100: begin e.lat = 3 + fs; e.pcen = 1 + int'(zr[fs + 2]); end
         6'b001000: begin e.lat = 4 + fs; e.regw = 1; end
         6'b000010: begin e.lat = 3 + fs; e.pcen = 2; end
         6'b000000: begin
            if (r_ok) begin e.lat = 4 + fs; e.regw = 1; e.rd = 1'b1; e.alu = alu; end
            else      begin e.lat = 3 + fs; e.ill = 1; end
         end
         default:   begin e.lat = 2 + fs; e.ill = 1; end
      endcase
      return e;
   endfunction

   // Run one instruction starting in the current FETCH cycle and count what the DUT asserts.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] funct,
                            input logic [39:0] rdy, input logic [39:0] zr,
                            output int lat, output int regw, output int memw,
                            output int pcen, output int ill, output int irw,
                            output logic rd_w, output logic mtr_w, output logic [2:0] alu_x,
                            output logic timed_out);
      int fs;
      bit left;
      fs = 0;
      while (fs < 30 && !rdy[fs]) fs++;
      lat = 0; regw = 0; memw = 0; pcen = 0; ill = 0; irw = 0;
      rd_w = 1'b0; mtr_w = 1'b0; alu_x = 3'b000;
      left = 1'b0;
      timed_out = 1'b1;
      Op = op; Funct = funct; MemReady = rdy[0]; Zero = zr[0];
      #1;
      for (int c = 0; c < 40; c++) begin
         if (c > 0) cyc(1'b0, rdy[c], zr[c]);
         if (left && State == 4'd0) begin
            lat = c;
            timed_out = 1'b0;
            break;
         end
         if (State != 4'd0) left = 1'b1;
         regw += int'(RegWrite);
         memw += int'(MemWrite);
         pcen += int'(PCEn);
         ill  += int'(Illegal);
         irw  += int'(IRWrite);
         if (RegWrite) begin rd_w = RegDst; mtr_w = MemtoReg; end
         if (c == fs + 2) alu_x = ALUControl;
      end
   endtask

   initial begin
      int lat, regw, memw, pcen, ill, irw;
      logic rd_w, mtr_w, tout;
      logic [2:0] alu_x;
      logic [39:0] rdy, zr;
      logic [5:0] fn_tab [5];
      exp_t e;

      fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      //          op          funct       z     fs ms lat rw mw pc il
      vecs[0]  = '{6'b100011, 6'b000000, 1'b0, 0, 0, 5, 1, 0, 1, 0};
      vecs[1]  = '{6'b100011, 6'b000000, 1'b0, 2, 1, 8, 1, 0, 1, 0};
      vecs[2]  = '{6'b101011, 6'b000000, 1'b0, 0, 0, 4, 0, 1, 1, 0};
      vecs[3]  = '{6'b101011, 6'b000000, 1'b0, 1, 2, 7, 0, 3, 1, 0};
      vecs[4]  = '{6'b000100, 6'b000000, 1'b1, 0, 0, 3, 0, 0, 2, 0};
      vecs[5]  = '{6'b000100, 6'b000000, 1'b0, 1, 0, 4, 0, 0, 1, 0};
      vecs[6]  = '{6'b001000, 6'b000000, 1'b0, 0, 0, 4, 1, 0, 1, 0};
      vecs[7]  = '{6'b000010, 6'b000000, 1'b0, 0, 0, 3, 0, 0, 2, 0};
      vecs[8]  = '{6'b000000, 6'b100000, 1'b0, 0, 0, 4, 1, 0, 1, 0};
      vecs[9]  = '{6'b000000, 6'b000001, 1'b0, 0, 0, 3, 0, 0, 1, 1};
      vecs[10] = '{6'b111111, 6'b000000, 1'b0, 0, 0, 2, 0, 0, 1, 1};
      vecs[11] = '{6'b000011, 6'b000000, 1'b0, 1, 0, 3, 0, 0, 1, 1};

      RST = 1'b1; MemReady = 1'b1; Zero = 1'b0; Op = 6'b000000; Funct = 6'b000000;

      // Reset held two cycles: FETCH decode with every enable suppressed.
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, 1'b1, 1'b0);
         check("rst_state", State, 4'd0);
         check("rst_enables", {MemWrite, IRWrite, RegWrite, PCEn, Illegal}, 5'b0);
         check("rst_alusrcb", ALUSrcB, 2'b01);
      end

      // Release into a lw with MemReady high: states 0,1,2,3,4 then FETCH.
      Op = 6'b100011;
      cyc(1'b0, 1'b1, 1'b0);
      check("rel_state", State, 4'd0);
      check("rel_irwrite", IRWrite, 1'b1);
      check("rel_pcen", PCEn, 1'b1);
      check("rel_alusrcb", ALUSrcB, 2'b01);
      cyc(1'b0, 1'b1, 1'b0);
      check("lw_decode", State, 4'd1);
      cyc(1'b0, 1'b1, 1'b0);
      check("lw_memadr", State, 4'd2);
      check("lw_memadr_srcb", ALUSrcB, 2'b10);
      cyc(1'b0, 1'b1, 1'b0);
      check("lw_memrd", State, 4'd3);
      check("lw_memrd_iord", IorD, 1'b1);
      cyc(1'b0, 1'b1, 1'b0);
      check("lw_memwb", State, 4'd4);
      check("lw_memwb_regwrite", RegWrite, 1'b1);
      check("lw_memwb_memtoreg", MemtoReg, 1'b1);
      cyc(1'b0, 1'b1, 1'b0);
      check("lw_back_fetch", State, 4'd0);

      // sw with MemReady low three cycles in MEMWR: MemWrite held four cycles.
      Op = 6'b101011;
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      check("sw_memadr", State, 4'd2);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, (i == 3), 1'b0);
         check("sw_memwr_state", State, 4'd5);
         check("sw_memwrite", MemWrite, 1'b1);
         check("sw_no_regwrite", RegWrite, 1'b0);
      end
      cyc(1'b0, 1'b1, 1'b0);
      check("sw_back_fetch", State, 4'd0);
      check("sw_done_memwrite", MemWrite, 1'b0);

      // beq taken and not taken.
      for (int z = 1; z >= 0; z--) begin
         Op = 6'b000100;
         cyc(1'b0, 1'b1, 1'b0);
         cyc(1'b0, 1'b1, z[0]);
         check("beq_state", State, 4'd8);
         check("beq_pcsrc", PCSrc, 2'b01);
         check("beq_alu", ALUControl, 3'b110);
         check("beq_pcen", PCEn, z[0]);
         cyc(1'b0, 1'b1, 1'b0);
         check("beq_back_fetch", State, 4'd0);
      end

      // R-type slt, then an unsupported funct.
      Op = 6'b000000; Funct = 6'b101010;
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      check("slt_exec_state", State, 4'd6);
      check("slt_alu", ALUControl, 3'b111);
      cyc(1'b0, 1'b1, 1'b0);
      check("slt_aluwb_state", State, 4'd7);
      check("slt_regdst", RegDst, 1'b1);
      check("slt_regwrite", RegWrite, 1'b1);
      cyc(1'b0, 1'b1, 1'b0);
      Funct = 6'b000000;
      cyc(1'b0, 1'b1, 1'b0);
      check("badfn_decode_ill", Illegal, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      check("badfn_exec_ill", Illegal, 1'b1);
      check("badfn_exec_regwrite", RegWrite, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      check("badfn_next_state", State, 4'd0);
      check("badfn_ill_drop", Illegal, 1'b0);

      // Unsupported opcode: one-cycle Illegal in DECODE.
      Op = 6'b111111;
      cyc(1'b0, 1'b1, 1'b0);
      check("badop_decode_state", State, 4'd1);
      check("badop_ill", Illegal, 1'b1);
      cyc(1'b0, 1'b1, 1'b0);
      check("badop_next_state", State, 4'd0);
      check("badop_ill_drop", Illegal, 1'b0);

      // Reset arriving during a stalled MEMWR aborts the write at once.
      Op = 6'b101011;
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      check("rstwr_memwr_state", State, 4'd5);
      check("rstwr_memwrite_before", MemWrite, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      check("rstwr_memwrite_dropped", MemWrite, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      check("rstwr_state_fetch", State, 4'd0);
      check("rstwr_no_memwrite", MemWrite, 1'b0);

      // Whole-instruction vectors.
      for (int i = 0; i < 12; i++) begin
         rdy = '1;
         for (int c = 0; c < vecs[i].fs; c++) rdy[c] = 1'b0;
         for (int k = 0; k < vecs[i].ms; k++) rdy[vecs[i].fs + 3 + k] = 1'b0;
         zr = vecs[i].zero ? '1 : '0;
         run_instr(vecs[i].op, vecs[i].funct, rdy, zr, lat, regw, memw, pcen, ill, irw,
                   rd_w, mtr_w, alu_x, tout);
         check($sformatf("vec%0d_timeout", i), tout, 1'b0);
         check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("vec%0d_regwrite", i), regw, vecs[i].regw);
         check($sformatf("vec%0d_memwrite", i), memw, vecs[i].memw);
         check($sformatf("vec%0d_pcen", i), pcen, vecs[i].pcen);
         check($sformatf("vec%0d_illegal", i), ill, vecs[i].ill);
         check($sformatf("vec%0d_irwrite", i), irw, 1);
      end

      // Randomized instruction stream against the model.
      for (int n = 0; n < 40; n++) begin
         logic [5:0] op, funct;
         int fs, ms;
         rdy = {$urandom, $urandom};
         zr  = {$urandom, $urandom};
         fs  = $urandom_range(0, 3);
         ms  = $urandom_range(0, 3);
         for (int c = 0; c < fs; c++) rdy[c] = 1'b0;
         rdy[fs] = 1'b1;
         for (int k = 0; k < ms; k++) rdy[fs + 3 + k] = 1'b0;
         rdy[fs + 3 + ms] = 1'b1;
         case ($urandom_range(0, 7))
            0:       op = 6'b100011;
            1:       op = 6'b101011;
            2:       op = 6'b000100;
            3:       op = 6'b001000;
            4:       op = 6'b000010;
            5, 6:    op = 6'b000000;
            default: op = 6'($urandom);
         endcase
         if ($urandom_range(0, 3) != 0) funct = fn_tab[$urandom_range(0, 4)];
         else                           funct = 6'($urandom);
         e = model(op, funct, rdy, zr);
         run_instr(op, funct, rdy, zr, lat, regw, memw, pcen, ill, irw,
                   rd_w, mtr_w, alu_x, tout);
         check($sformatf("rnd%0d_op%0h_timeout", n, op), tout, 1'b0);
         check($sformatf("rnd%0d_op%0h_latency", n, op), lat, e.lat);
         check($sformatf("rnd%0d_op%0h_regwrite", n, op), regw, e.regw);
         check($sformatf("rnd%0d_op%0h_memwrite", n, op), memw, e.memw);
         check($sformatf("rnd%0d_op%0h_pcen", n, op), pcen, e.pcen);
         check($sformatf("rnd%0d_op%0h_illegal", n, op), ill, e.ill);
         check($sformatf("rnd%0d_op%0h_irwrite", n, op), irw, 1);
         if (e.regw != 0) begin
            check($sformatf("rnd%0d_op%0h_regdst", n, op), rd_w, e.rd);
            check($sformatf("rnd%0d_op%0h_memtoreg", n, op), mtr_w, e.mtr);
         end
         if (op == 6'b000000 && e.ill == 0)
            check($sformatf("rnd%0d_fn%0h_alu", n, funct), alu_x, e.alu);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
